// File: rtl/dma_bus_master.sv
// dma_bus_master
// Byte-at-a-time memory-to-memory copy engine that borrows the CPU bus.
// It raises busrq_n, waits for busak_n, then alternates one read cycle
// and one write cycle per byte (2 cycles/byte). After BURST bytes it gives
// the bus back and re-requests it. A zero-length start only pulses done.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, abort          one-cycle start request (IDLE only), level abort
//   src, dst, len         transfer setup, latched on an accepted start
//   busrq_n / busak_n     bus request out / bus acknowledge in (active-low)
//   dma_a, dma_do, dma_di address, write data, read data
//   dma_mreq_n, dma_rd_n, dma_wr_n  active-low memory strobes
//   dma_en                high while driving the bus (RD or WR)
//   busy, done            not-IDLE flag, one-cycle end-of-transfer pulse
//   remaining             bytes not yet written
module dma_bus_master #(
  parameter int BURST = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] dma_a,
  output logic [7:0]  dma_do,
  input  logic [7:0]  dma_di,
  output logic        dma_mreq_n,
  output logic        dma_rd_n,
  output logic        dma_wr_n,
  output logic        dma_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] remaining
);

  localparam logic [15:0] BURST_LIM = 16'(BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_REL
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] src_q, dst_q, burst_q;
  logic [15:0] src_nxt, dst_nxt, burst_nxt, rem_nxt;
  logic        resume_q, resume_nxt;
  logic        done_nxt;

  // Next-state and next-datapath values. All outputs are registered from
  // these, so every strobe is a flop output and changes only on clk.
  always_comb begin
    state_nxt  = state;
    src_nxt    = src_q;
    dst_nxt    = dst_q;
    burst_nxt  = burst_q;
    rem_nxt    = remaining;
    resume_nxt = resume_q;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != 16'h0000) begin
            state_nxt  = S_REQ;
            src_nxt    = src;
            dst_nxt    = dst;
            rem_nxt    = len;
            resume_nxt = 1'b0;
          end else begin
            rem_nxt  = 16'h0000;
            done_nxt = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (abort) begin
          state_nxt  = S_REL;
          resume_nxt = 1'b0;
        end else if (!busak_n) begin
          state_nxt = S_RD;
          burst_nxt = 16'h0000;
        end
      end
      S_RD: begin
        // Aborting here skips the write; the read data is simply dropped.
        if (abort) begin
          state_nxt  = S_REL;
          resume_nxt = 1'b0;
        end else begin
          state_nxt = S_WR;
        end
      end
      S_WR: begin
        // The write in flight always completes, abort only picks the exit.
        src_nxt   = src_q + 16'h0001;
        dst_nxt   = dst_q + 16'h0001;
        rem_nxt   = remaining - 16'h0001;
        burst_nxt = burst_q + 16'h0001;
        if (rem_nxt == 16'h0000 || abort) begin
          state_nxt  = S_REL;
          resume_nxt = 1'b0;
        end else if (burst_nxt == BURST_LIM) begin
          state_nxt  = S_REL;
          resume_nxt = 1'b1;
        end else begin
          state_nxt = S_RD;
        end
      end
      S_REL: begin
        if (busak_n) begin
          if (resume_q) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      resume_q   <= 1'b0;
      remaining  <= 16'h0000;
      busrq_n    <= 1'b1;
      dma_mreq_n <= 1'b1;
      dma_rd_n   <= 1'b1;
      dma_wr_n   <= 1'b1;
      dma_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dma_a      <= 16'h0000;
      dma_do     <= 8'h00;
    end else begin
      state      <= state_nxt;
      resume_q   <= resume_nxt;
      remaining  <= rem_nxt;
      done       <= done_nxt;
      busy       <= (state_nxt != S_IDLE);
      busrq_n    <= !(state_nxt inside {S_REQ, S_RD, S_WR});
      dma_mreq_n <= !(state_nxt inside {S_RD, S_WR});
      dma_rd_n   <= (state_nxt != S_RD);
      dma_wr_n   <= (state_nxt != S_WR);
      dma_en     <= (state_nxt inside {S_RD, S_WR});
      dma_a      <= (state_nxt == S_RD) ? src_nxt :
                    (state_nxt == S_WR) ? dst_nxt : 16'h0000;
      // WR is only entered from RD, so this edge is the read-capture edge
      // and dma_do doubles as the byte holding register.
      dma_do     <= (state_nxt == S_WR) ? dma_di : 8'h00;
    end
  end

  // Address and burst counters need no reset: they are loaded before use.
  always_ff @(posedge clk) begin
    src_q   <= src_nxt;
    dst_q   <= dst_nxt;
    burst_q <= burst_nxt;
  end

endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master
// Drives two dma_bus_master instances (BURST=16 and BURST=2) against a
// byte-addressed memory model and a CPU bus arbiter model. Expected
// memory images are computed as a sequential byte copy over a snapshot
// of memory; expected tenure counts come from ceil(bytes/BURST).
module tb_dma_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, abort, busak_n, sel;
  logic        start0, start1;
  logic [15:0] src, dst, len;
  logic [7:0]  dma_di;

  logic [1:0]  busrq_v, mreq_v, rd_v, wr_v, en_v, busy_v, done_v;
  logic [15:0] a_v   [2];
  logic [15:0] rem_v [2];
  logic [7:0]  do_v  [2];

  logic        o_busrq_n, o_mreq_n, o_rd_n, o_wr_n, o_en, o_busy, o_done;
  logic [15:0] o_dma_a, o_remaining;
  logic [7:0]  o_dma_do;

  assign o_busrq_n   = busrq_v[sel];
  assign o_mreq_n    = mreq_v[sel];
  assign o_rd_n      = rd_v[sel];
  assign o_wr_n      = wr_v[sel];
  assign o_en        = en_v[sel];
  assign o_busy      = busy_v[sel];
  assign o_done      = done_v[sel];
  assign o_dma_a     = a_v[sel];
  assign o_remaining = rem_v[sel];
  assign o_dma_do    = do_v[sel];

  logic [7:0] mem     [65536];
  logic [7:0] exp_mem [65536];
  assign dma_di = mem[o_dma_a];

  dma_bus_master #(.BURST(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort),
    .src(src), .dst(dst), .len(len),
    .busrq_n(busrq_v[0]), .busak_n(busak_n),
    .dma_a(a_v[0]), .dma_do(do_v[0]), .dma_di(dma_di),
    .dma_mreq_n(mreq_v[0]), .dma_rd_n(rd_v[0]), .dma_wr_n(wr_v[0]),
    .dma_en(en_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .remaining(rem_v[0])
  );

  dma_bus_master #(.BURST(2)) u_dut_b2 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort),
    .src(src), .dst(dst), .len(len),
    .busrq_n(busrq_v[1]), .busak_n(busak_n),
    .dma_a(a_v[1]), .dma_do(do_v[1]), .dma_di(dma_di),
    .dma_mreq_n(mreq_v[1]), .dma_rd_n(rd_v[1]), .dma_wr_n(wr_v[1]),
    .dma_en(en_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .remaining(rem_v[1])
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  int done_cnt, tenures, gap_viol, idle_viol, ack_viol;
  bit busrq_low_seen, busy_seen;
  bit prev_rd, prev_wr, prev_busrq;
  bit arb_en;
  int ack_delay, ack_wait;
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_log.delete();
    wr_log.delete();
    done_cnt = 0; tenures = 0; gap_viol = 0; idle_viol = 0; ack_viol = 0;
    busrq_low_seen = 1'b0; busy_seen = 1'b0;
  endtask

  // One clock: sample on the falling edge, log bus activity, update the
  // memory on writes, and run the CPU arbiter.
  task automatic tick();
    @(negedge clk);
    if (!o_rd_n) rd_log.push_back(o_dma_a);
    if (!o_wr_n) begin
      mem[o_dma_a] = o_dma_do;
      wr_log.push_back(o_dma_a);
    end
    if (o_done) done_cnt++;
    if (!o_busrq_n) busrq_low_seen = 1'b1;
    if (o_busy) busy_seen = 1'b1;
    if (prev_busrq && !o_busrq_n) begin
      tenures++;
      if (!busak_n) ack_viol++;
    end
    if (prev_rd && o_wr_n && !abort) gap_viol++;
    if (prev_wr && !o_busrq_n && o_rd_n) gap_viol++;
    if (!o_en && ({o_dma_a, o_dma_do} != 24'h0 || {o_mreq_n, o_rd_n, o_wr_n} != 3'b111))
      idle_viol++;
    if (o_en && (o_mreq_n || o_busrq_n || (o_rd_n == o_wr_n))) idle_viol++;
    prev_rd    = !o_rd_n;
    prev_wr    = !o_wr_n;
    prev_busrq = o_busrq_n;
    if (arb_en) begin
      if (o_busrq_n) begin
        ack_wait = 0;
        busak_n  = 1'b1;
      end else if (busak_n) begin
        ack_wait++;
        if (ack_wait >= ack_delay) busak_n = 1'b0;
      end
    end
  endtask

  task automatic run_xfer(input bit b2, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input int abort_rd, input int dly);
    int nbytes, burst, t, mm, amm;
    sel = b2;
    burst = b2 ? 2 : 16;
    ack_delay = dly;
    exp_mem = mem;
    nbytes = (abort_rd != 0) ? abort_rd - 1 : int'(n);
    for (int i = 0; i < nbytes; i++)
      exp_mem[16'(int'(d) + i)] = exp_mem[16'(int'(s) + i)];
    clear_mon();
    src = s; dst = d; len = n;
    if (b2) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      tick();
      t++;
      if (abort_rd != 0 && !o_rd_n && rd_log.size() == abort_rd) abort = 1'b1;
    end
    chk("done_within_budget", 32'(done_cnt != 0), 32'd1);
    repeat (3) tick();
    abort = 1'b0;
    mm = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) mm++;
    amm = 0;
    foreach (rd_log[i]) if (rd_log[i] !== 16'(int'(s) + i)) amm++;
    foreach (wr_log[i]) if (wr_log[i] !== 16'(int'(d) + i)) amm++;
    chk("done_pulses", done_cnt, 32'd1);
    chk("bytes_written", rd_log.size() >= 0 ? wr_log.size() : 0, nbytes);
    chk("bytes_read", rd_log.size(), (abort_rd != 0) ? abort_rd : int'(n));
    chk("mem_mismatches", mm, 32'd0);
    chk("addr_seq_mismatches", amm, 32'd0);
    chk("remaining", 32'(o_remaining), 32'(int'(n) - nbytes));
    chk("busrq_n_after", 32'(o_busrq_n), 32'd1);
    chk("busy_after", 32'(o_busy), 32'd0);
    chk("byte_gaps", gap_viol, 32'd0);
    chk("strobe_rules", idle_viol, 32'd0);
    chk("ack_before_rereq", ack_viol, 32'd0);
    if (abort_rd == 0) chk("tenures", tenures, (nbytes + burst - 1) / burst);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; busak_n = 1'b1; sel = 1'b0;
    arb_en = 1'b1; ack_delay = 2; ack_wait = 0;
    prev_rd = 1'b0; prev_wr = 1'b0; prev_busrq = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    clear_mon();
    repeat (3) tick();
    chk("rst_busrq_n", 32'(o_busrq_n), 32'd1);
    chk("rst_strobes_en", 32'({o_mreq_n, o_rd_n, o_wr_n, o_en}), 32'hE);
    chk("rst_busy_done", 32'({o_busy, o_done}), 32'd0);
    chk("rst_remaining", 32'(o_remaining), 32'd0);
    chk("rst_addr_data", 32'({o_dma_a, o_dma_do}), 32'd0);
    chk("rst_busy_b2", 32'(busy_v[1]), 32'd0);
    reset_n = 1'b1;
    tick();

    // Acknowledge while nobody is requesting must be ignored.
    arb_en = 1'b0; busak_n = 1'b0;
    clear_mon();
    repeat (5) tick();
    chk("spurious_ack_busy", 32'(busy_seen), 32'd0);
    chk("spurious_ack_strobes", idle_viol, 32'd0);
    busak_n = 1'b1; arb_en = 1'b1;
    tick();

    // Zero-length start.
    clear_mon();
    len = 16'h0000; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("len0_done_next_cycle", 32'(o_done), 32'd1);
    tick();
    chk("len0_done_one_cycle", 32'(o_done), 32'd0);
    repeat (4) tick();
    chk("len0_no_busrq", 32'(busrq_low_seen), 32'd0);
    chk("len0_no_busy", 32'(busy_seen), 32'd0);
    chk("len0_done_count", done_cnt, 32'd1);

    // Directed three-byte copy.
    mem[16'hC80D] = 8'hC0; mem[16'hC80E] = 8'hA0; mem[16'hC80F] = 8'hCB;
    run_xfer(1'b0, 16'hC80D, 16'h0100, 16'd3, 0, 2);
    chk("copy_0100", 32'(mem[16'h0100]), 32'hC0);
    chk("copy_0101", 32'(mem[16'h0101]), 32'hA0);
    chk("copy_0102", 32'(mem[16'h0102]), 32'hCB);
    chk("copy_tenure_single", tenures, 32'd1);

    // Burst of 2 splitting five bytes into three tenures.
    run_xfer(1'b1, 16'h2000, 16'h5000, 16'd5, 0, 1);

    // Independent address wrap.
    run_xfer(1'b0, 16'hFFFF, 16'h7FFF, 16'd2, 0, 1);

    // Abort during the second read.
    run_xfer(1'b0, 16'h1000, 16'h2000, 16'd4, 2, 1);

    // Reset asserted in the middle of a write.
    sel = 1'b0; clear_mon();
    src = 16'h3000; dst = 16'h4000; len = 16'd8; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    t = 0;
    while (o_wr_n && t < 100) begin tick(); t++; end
    chk("reset_test_reached_wr", 32'(o_wr_n), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_busrq_n", 32'(o_busrq_n), 32'd1);
    chk("async_rst_wr_n", 32'(o_wr_n), 32'd1);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    chk("async_rst_remaining", 32'(o_remaining), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(o_busy), 32'd0);
    repeat (3) tick();
    chk("post_rst_no_done", done_cnt, 32'd0);
    run_xfer(1'b0, 16'h3000, 16'h4000, 16'd8, 0, 3);

    // Randomized transfers on both burst sizes.
    for (int k = 0; k < 8; k++) begin
      run_xfer(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
               16'($urandom_range(1, 40)), 0, int'($urandom_range(1, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_bus_master.md
DMA_BUS_MASTER -- requirements
Module: dma_bus_master

Interface
- REQ-001 Parameter BURST, default 16, maximum bytes per bus tenure before the bus SHALL be released (range 1..65535).
- REQ-002 clk  input  1  single clock; all state changes on rising edge.
- REQ-003 reset_n  input  1  reset, asynchronous, active-low.
- REQ-004 start  input  1  one-cycle request to begin a transfer; sampled in IDLE only.
- REQ-005 abort  input  1  level; terminates the transfer early.
- REQ-006 src  input  16  source address, latched on accepted start.
- REQ-007 dst  input  16  destination address, latched on accepted start.
- REQ-008 len  input  16  byte count, latched on accepted start; 0 means no transfer.
- REQ-009 busrq_n  output  1  bus request to CPU, active-low.
- REQ-010 busak_n  input  1  bus acknowledge from CPU, active-low.
- REQ-011 dma_a  output  16  memory address while mastering.
- REQ-012 dma_do  output  8  write data.
- REQ-013 dma_di  input  8  read data from memory.
- REQ-014 dma_mreq_n, dma_rd_n, dma_wr_n  output  1 each  memory strobes, active-low.
- REQ-015 dma_en  output  1  high when DMA drives the bus (RD or WR state).
- REQ-016 busy  output  1  high in every state except IDLE.
- REQ-017 done  output  1  one-cycle pulse at transfer end.
- REQ-018 remaining  output  16  bytes not yet written.

Function
- REQ-019 States SHALL be IDLE, REQ, RD, WR, REL.
- REQ-020 IDLE: start with len!=0 -> REQ, latching src/dst/len; start with len==0 -> stay IDLE, done pulses next cycle; start outside IDLE ignored.
- REQ-021 REQ: busrq_n=0; on busak_n==0 sampled -> RD, burst counter cleared; abort -> REL.
- REQ-022 RD (one cycle): dma_a=src, dma_mreq_n=0, dma_rd_n=0; dma_di captured into data register on exit edge; -> WR; abort -> REL without capture or write.
- REQ-023 WR (one cycle): dma_a=dst, dma_do=data, dma_mreq_n=0, dma_wr_n=0; on exit src+1, dst+1, remaining-1, burst+1.
- REQ-024 WR exit: remaining reaches 0 or abort -> REL(final); burst==BURST -> REL(resume); else -> RD.
- REQ-025 REL: busrq_n=1; on busak_n==1 sampled -> REQ if resume, else IDLE with done pulse in that same exit cycle.
- REQ-026 abort during WR SHALL complete that write before releasing.
- REQ-027 Address increment SHALL wrap modulo 2^16 (FFFF -> 0000) for src and dst independently.
- REQ-028 Outside RD/WR: strobes=1, dma_en=0, dma_a=0000, dma_do=00.
- REQ-029 Throughput: 2 cycles per byte while the bus is held; no idle cycles between consecutive bytes in a burst.
- REQ-030 busak_n low while not requesting SHALL be ignored.
- REQ-031 busrq_n, strobes and dma_en SHALL be registered (glitch-free).

Reset
- REQ-032 reset_n low SHALL immediately force IDLE, busrq_n=1, strobes=1, dma_en=0, busy=0, done=0, remaining=0000, dma_a=0000, dma_do=00.
- REQ-033 Reset mid-transfer SHALL abandon the transfer with no done pulse; the first rising edge after release SHALL be in IDLE.

Verification
- REQ-034 mem[C80D..C80F]=C0,A0,CB; start src=C80D dst=0100 len=3; busak_n low 2 cycles after busrq_n -> mem[0100..0102]=C0,A0,CB, 3 RD + 3 WR back-to-back, one done pulse, busrq_n=1 after, remaining=0000.
- REQ-035 start len=0000 -> done high exactly one cycle after start, busrq_n never low, busy never high.
- REQ-036 BURST=2, len=5 -> busrq_n low for three tenures (2,2,1 bytes), each ended by busak_n high before next request; all 5 bytes copied.
- REQ-037 src=FFFF dst=7FFF len=2 -> reads FFFF then 0000; writes 7FFF then 8000.
- REQ-038 len=4, abort raised during second RD -> exactly 1 byte written, remaining=0003, done pulse, busrq_n=1.
- REQ-039 reset_n low during WR -> busrq_n=1 and dma_wr_n=1 before next clock edge; busy=0; new start afterwards runs normally.
